// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Purpose  : Requester side of the divide-engine handshake in EX. Converts a
//            decoded RISC-V M-extension divide/remainder into unsigned
//            magnitudes for an iterative engine. Resolves divide-by-zero and
//            signed overflow locally, without starting the engine. Applies
//            sign correction and W-form sign extension to the engine result.
//            Stalls IF/ID/EX while an operation is outstanding.
// Ports    : clk, rst (async, active-low)
//            ex_valid, inst_opcode, op1, op2, flush     - request side
//            eng_start, eng_dividend, eng_divisor       - to engine
//            eng_quotient, eng_remainder, eng_finish    - from engine
//            div_stall, div_rem_data, div_finish        - to pipeline
// Revision : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [7:0]      inst_opcode,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            eng_start,
    output logic [XLEN-1:0] eng_dividend,
    output logic [XLEN-1:0] eng_divisor,
    input  logic [XLEN-1:0] eng_quotient,
    input  logic [XLEN-1:0] eng_remainder,
    input  logic            eng_finish,
    output logic            div_stall,
    output logic [XLEN-1:0] div_rem_data,
    output logic            div_finish
);

    localparam logic [7:0] INST_DIV   = 8'h40;
    localparam logic [7:0] INST_DIVU  = 8'h41;
    localparam logic [7:0] INST_REM   = 8'h42;
    localparam logic [7:0] INST_REMU  = 8'h43;
    localparam logic [7:0] INST_DIVW  = 8'h44;
    localparam logic [7:0] INST_DIVUW = 8'h45;
    localparam logic [7:0] INST_REMW  = 8'h46;
    localparam logic [7:0] INST_REMUW = 8'h47;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic [XLEN-1:0]   dividend_q, dividend_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic              signed_q, signed_d, word_q, word_d, rem_q, rem_d;

    // Low word sign-extended to the full width.
    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    // Opcode decode
    logic op_recog, op_signed, op_word, op_rem;
    always_comb begin
        op_recog  = 1'b1;
        op_signed = 1'b0;
        op_word   = 1'b0;
        op_rem    = 1'b0;
        case (inst_opcode)
            INST_DIV:   op_signed = 1'b1;
            INST_DIVU:  ;
            INST_REM:   begin op_signed = 1'b1; op_rem = 1'b1; end
            INST_REMU:  op_rem = 1'b1;
            INST_DIVW:  begin op_signed = 1'b1; op_word = 1'b1; end
            INST_DIVUW: op_word = 1'b1;
            INST_REMW:  begin op_signed = 1'b1; op_word = 1'b1; op_rem = 1'b1; end
            INST_REMUW: begin op_word = 1'b1; op_rem = 1'b1; end
            default:    op_recog = 1'b0;
        endcase
    end

    // Operand preparation
    logic [XLEN-1:0] a, b, mag_a, mag_b;
    logic            sa, sb;
    assign a     = op_word ? (op_signed ? sext32(op1) : {{(XLEN-32){1'b0}}, op1[31:0]}) : op1;
    assign b     = op_word ? (op_signed ? sext32(op2) : {{(XLEN-32){1'b0}}, op2[31:0]}) : op2;
    assign sa    = op_signed & a[XLEN-1];
    assign sb    = op_signed & b[XLEN-1];
    assign mag_a = sa ? (~a + 1'b1) : a;
    assign mag_b = sb ? (~b + 1'b1) : b;

    logic accept, div_zero, overflow;
    logic [XLEN-1:0] special_res;
    assign accept   = (state_q == S_IDLE) & ex_valid & op_recog & ~flush;
    assign div_zero = (b == '0);
    // For W ops 'a' is already sign-extended, so only the low word matters.
    assign overflow = op_signed & (b == '1) &
                      (op_word ? (a[31:0] == 32'h8000_0000) : (a == MIN_NEG));

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op_rem ? (op_word ? sext32(a) : a) : '1;
        else if (overflow)
            special_res = op_rem ? '0 : a;
    end

    // Engine result correction using the classification captured at issue
    logic [XLEN-1:0] q_corr, r_corr, sel_res, final_res;
    assign q_corr    = (signed_q & (sa_q ^ sb_q)) ? (~eng_quotient + 1'b1) : eng_quotient;
    assign r_corr    = (signed_q & sa_q) ? (~eng_remainder + 1'b1) : eng_remainder;
    assign sel_res   = rem_q ? r_corr : q_corr;
    assign final_res = word_q ? sext32(sel_res) : sel_res;

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        signed_d   = signed_q;
        word_d     = word_q;
        rem_d      = rem_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (div_zero || overflow) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        dividend_d = mag_a;
                        divisor_d  = mag_b;
                        sa_d       = sa;
                        sb_d       = sb;
                        signed_d   = op_signed;
                        word_d     = op_word;
                        rem_d      = op_rem;
                        start_d    = 1'b1;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A result arriving together with a flush is simply dropped.
                if (flush)
                    state_d = eng_finish ? S_IDLE : S_DRAIN;
                else if (eng_finish) begin
                    result_d = final_res;
                    state_d  = S_DONE;
                end
            end
            S_DRAIN: begin
                if (eng_finish)
                    state_d = S_IDLE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            signed_q   <= 1'b0;
            word_q     <= 1'b0;
            rem_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            signed_q   <= signed_d;
            word_q     <= word_d;
            rem_q      <= rem_d;
        end
    end

    assign eng_start    = start_q;
    assign eng_dividend = dividend_q;
    assign eng_divisor  = divisor_q;
    assign div_rem_data = result_q;
    assign div_finish   = (state_q == S_DONE) & ~flush;
    assign div_stall    = accept | (state_q == S_WAIT) | (state_q == S_DRAIN);

endmodule
`default_nettype wire
